// File: rtl/int_ctrl_n_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | int_ctrl_n_if : core-side bus of the nestable interrupt controller          |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
interface int_ctrl_n_if #(
  parameter int NUM_IRQ = 4,
  parameter int WIDTH   = 16
);
  logic [NUM_IRQ-1:0] Irq;
  logic               IntOp;
  logic [2:0]         IntSub;
  logic [3:0]         FlagsIn;
  logic               IntAck;
  logic               IntReq;
  logic [WIDTH-1:0]   Vector;
  logic [3:0]         FlagsOut;
  logic               FlagsLoad;
  logic               IntEnable;
  logic [NUM_IRQ-1:0] InService;
  logic               NestErr;

  modport master (
    output Irq, IntOp, IntSub, FlagsIn, IntAck,
    input  IntReq, Vector, FlagsOut, FlagsLoad, IntEnable, InService, NestErr
  );

  modport slave (
    input  Irq, IntOp, IntSub, FlagsIn, IntAck,
    output IntReq, Vector, FlagsOut, FlagsLoad, IntEnable, InService, NestErr
  );
endinterface
`default_nettype wire

// File: rtl/int_ctrl_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | int_ctrl_n : N-channel prioritised, nestable interrupt controller           |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module int_ctrl_n #(
  parameter int               NUM_IRQ   = 4,
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] VEC_BASE  = WIDTH'('h0010),
  parameter int               VEC_SHIFT = 2
) (
  input  wire logic     Clock,
  input  wire logic     nReset,
  int_ctrl_n_if.slave   bus
);

  localparam int c_IW  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int c_LW  = $clog2(NUM_IRQ + 1);
  localparam int c_SPW = $clog2(DEPTH + 1);

  localparam logic [2:0] c_RETI = 3'd0;
  localparam logic [2:0] c_ENAI = 3'd1;
  localparam logic [2:0] c_DISI = 3'd2;
  localparam logic [2:0] c_LDF  = 3'd3;
  localparam logic [2:0] c_STF  = 3'd4;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t             state_q;
  logic               req_q;
  logic [c_IW-1:0]    idx_q;
  logic [WIDTH-1:0]   vec_q;
  logic [NUM_IRQ-1:0] irq_prev_q, pending_q, pending_d;
  logic [NUM_IRQ-1:0] in_service_q, in_service_d;
  logic               ie_q, ie_d;
  logic [c_LW-1:0]    cur_lvl_q, cur_lvl_d;
  logic [c_SPW-1:0]   sp_q, sp_d;
  logic [3:0]         flags_out_q;
  logic               flags_load_q;
  logic               nest_err_q;

  logic               stk_ie_q    [DEPTH];
  logic [3:0]         stk_flags_q [DEPTH];
  logic [c_LW-1:0]    stk_lvl_q   [DEPTH];

  logic               w_hp_found, w_eligible, w_ack, w_op, w_empty, w_full;
  logic               w_pop, w_ldf, w_stf, w_reti_empty;
  logic [c_IW-1:0]    w_hp_idx;
  logic               w_top_ie;
  logic [3:0]         w_top_flags;
  logic [c_LW-1:0]    w_top_lvl;

  always_comb begin
    w_hp_found = 1'b0;
    w_hp_idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        w_hp_found = 1'b1;
        w_hp_idx   = c_IW'(i);
      end
    end

    w_empty  = (sp_q == '0);
    w_full   = (sp_q == c_SPW'(DEPTH));
    w_top_ie    = 1'b0;
    w_top_flags = '0;
    w_top_lvl   = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (sp_q == c_SPW'(e + 1)) begin
        w_top_ie    = stk_ie_q[e];
        w_top_flags = stk_flags_q[e];
        w_top_lvl   = stk_lvl_q[e];
      end
    end

    w_eligible = ie_q && !w_full && w_hp_found && (c_LW'(w_hp_idx) < cur_lvl_q);
    w_ack      = (state_q == S_REQ) && bus.IntAck;
    // An acknowledge in the same cycle always swallows the opcode strobe.
    w_op         = bus.IntOp && !bus.IntAck;
    w_pop        = w_op && (bus.IntSub == c_RETI) && !w_empty;
    w_reti_empty = w_op && (bus.IntSub == c_RETI) && w_empty;
    w_ldf        = w_op && (bus.IntSub == c_LDF) && !w_empty;
    w_stf        = w_op && (bus.IntSub == c_STF) && !w_empty;

    ie_d = ie_q;
    if (w_ack)                                    ie_d = 1'b0;
    else if (w_op && (bus.IntSub == c_ENAI))      ie_d = 1'b1;
    else if (w_op && (bus.IntSub == c_DISI))      ie_d = 1'b0;
    else if (w_pop)                               ie_d = w_top_ie;

    pending_d    = pending_q;
    in_service_d = in_service_q;
    cur_lvl_d    = cur_lvl_q;
    sp_d         = sp_q;
    if (w_ack) begin
      pending_d    = pending_d & ~(NUM_IRQ'(1) << idx_q);
      in_service_d = in_service_d | (NUM_IRQ'(1) << idx_q);
      cur_lvl_d    = c_LW'(idx_q);
      sp_d         = sp_q + c_SPW'(1);
    end else if (w_pop) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (cur_lvl_q == c_LW'(i)) in_service_d[i] = 1'b0;
      end
      cur_lvl_d = w_top_lvl;
      sp_d      = sp_q - c_SPW'(1);
    end
    pending_d = pending_d | (bus.Irq & ~irq_prev_q);
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      idx_q        <= '0;
      vec_q        <= VEC_BASE;
      irq_prev_q   <= bus.Irq;
      pending_q    <= '0;
      in_service_q <= '0;
      ie_q         <= 1'b0;
      cur_lvl_q    <= c_LW'(NUM_IRQ);
      sp_q         <= '0;
      flags_out_q  <= '0;
      flags_load_q <= 1'b0;
      nest_err_q   <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        stk_ie_q[e]    <= 1'b0;
        stk_flags_q[e] <= '0;
        stk_lvl_q[e]   <= '0;
      end
    end else begin
      irq_prev_q   <= bus.Irq;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      ie_q         <= ie_d;
      cur_lvl_q    <= cur_lvl_d;
      sp_q         <= sp_d;
      flags_load_q <= w_pop || w_ldf;
      nest_err_q   <= nest_err_q || w_reti_empty;
      if (w_pop || w_ldf) flags_out_q <= w_top_flags;

      for (int e = 0; e < DEPTH; e++) begin
        if (w_ack && (sp_q == c_SPW'(e))) begin
          stk_ie_q[e]    <= ie_q;
          stk_flags_q[e] <= bus.FlagsIn;
          stk_lvl_q[e]   <= cur_lvl_q;
        end
        if (w_stf && (sp_q == c_SPW'(e + 1))) stk_flags_q[e] <= bus.FlagsIn;
      end

      case (state_q)
        S_IDLE: begin
          if (w_eligible) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            idx_q   <= w_hp_idx;
            vec_q   <= VEC_BASE + (WIDTH'(w_hp_idx) << VEC_SHIFT);
          end
        end
        S_REQ: begin
          // Losing IE without an acknowledge withdraws the request; pending stays.
          if (w_ack || !ie_d) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IntReq    = req_q;
  assign bus.Vector    = vec_q;
  assign bus.FlagsOut  = flags_out_q;
  assign bus.FlagsLoad = flags_load_q;
  assign bus.IntEnable = ie_q;
  assign bus.InService = in_service_q;
  assign bus.NestErr   = nest_err_q;

endmodule
`default_nettype wire
